// File: rtl/anycore_l15_reqdecoder.sv
// Anycore -> L1.5 request bridge: buffers ifetch/load/store requests in one-entry
// slots and issues them one at a time, round-robin, with a val/header_ack handshake.
module anycore_l15_reqdecoder #(
    parameter int PADDR_W   = 40,
    parameter int IC_OFFSET = 5,
    parameter int DC_OFFSET = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               anycore_ic2mem_reqvalid,
    input  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr,
    input  logic               anycore_dc2mem_ldvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr,
    input  logic               anycore_dc2mem_stvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_staddr,
    input  logic [63:0]        anycore_dc2mem_stdata,
    input  logic [1:0]         anycore_dc2mem_stsize,
    output logic               transducer_l15_val,
    output logic [4:0]         transducer_l15_rqtype,
    output logic [2:0]         transducer_l15_size,
    output logic [PADDR_W-1:0] transducer_l15_address,
    output logic [63:0]        transducer_l15_data,
    output logic               transducer_l15_nc,
    output logic               transducer_l15_threadid,
    input  logic               l15_transducer_header_ack,
    output logic               anycore_req_overflow
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    localparam logic [1:0] C_IC = 2'd0;
    localparam logic [1:0] C_LD = 2'd1;
    localparam logic [1:0] C_ST = 2'd2;

    localparam logic [PADDR_W-1:0] IC_MASK = ~PADDR_W'((64'd1 << IC_OFFSET) - 64'd1);
    localparam logic [PADDR_W-1:0] DC_MASK = ~PADDR_W'((64'd1 << DC_OFFSET) - 64'd1);

    // Byte-swap the low 2^sz bytes into L1.5 (big-endian) order, then replicate to 64 bits.
    function automatic logic [63:0] f_st_data(input logic [63:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    return {8{d[7:0]}};
            2'd1:    return {4{d[7:0], d[15:8]}};
            2'd2:    return {2{d[7:0], d[15:8], d[23:16], d[31:24]}};
            default: return {d[7:0], d[15:8], d[23:16], d[31:24],
                             d[39:32], d[47:40], d[55:48], d[63:56]};
        endcase
    endfunction

    state_t             r_state;
    logic [1:0]         r_last;
    logic [1:0]         r_gnt;
    logic               r_ic_vld, r_ld_vld, r_st_vld;
    logic [PADDR_W-1:0] r_ic_addr, r_ld_addr, r_st_addr;
    logic [63:0]        r_st_data;
    logic [1:0]         r_st_size;
    logic               r_val;
    logic [4:0]         r_rqtype;
    logic [2:0]         r_size;
    logic [PADDR_W-1:0] r_addr;
    logic [63:0]        r_data;
    logic               r_ovf;

    logic       w_ack, w_rel_ic, w_rel_ld, w_rel_st;
    logic       w_cap_ic, w_cap_ld, w_cap_st, w_drop;
    logic       w_any;
    logic [1:0] w_win;

    assign w_ack    = (r_state == S_ISSUE) && l15_transducer_header_ack;
    assign w_rel_ic = w_ack && (r_gnt == C_IC);
    assign w_rel_ld = w_ack && (r_gnt == C_LD);
    assign w_rel_st = w_ack && (r_gnt == C_ST);

    // A full slot can still accept a new pulse on the very cycle it is released.
    assign w_cap_ic = anycore_ic2mem_reqvalid && (!r_ic_vld || w_rel_ic);
    assign w_cap_ld = anycore_dc2mem_ldvalid  && (!r_ld_vld || w_rel_ld);
    assign w_cap_st = anycore_dc2mem_stvalid  && (!r_st_vld || w_rel_st);
    assign w_drop   = (anycore_ic2mem_reqvalid && !w_cap_ic) ||
                      (anycore_dc2mem_ldvalid  && !w_cap_ld) ||
                      (anycore_dc2mem_stvalid  && !w_cap_st);

    assign w_any = r_ic_vld || r_ld_vld || r_st_vld;

    always_comb begin
        w_win = C_IC;
        case (r_last)
            C_IC:    w_win = r_ld_vld ? C_LD : (r_st_vld ? C_ST : C_IC);
            C_LD:    w_win = r_st_vld ? C_ST : (r_ic_vld ? C_IC : C_LD);
            default: w_win = r_ic_vld ? C_IC : (r_ld_vld ? C_LD : C_ST);
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_cap_ic) r_ic_addr <= anycore_ic2mem_reqaddr;
        if (w_cap_ld) r_ld_addr <= anycore_dc2mem_ldaddr;
        if (w_cap_st) begin
            r_st_addr <= anycore_dc2mem_staddr;
            r_st_data <= anycore_dc2mem_stdata;
            r_st_size <= anycore_dc2mem_stsize;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= C_ST;
            r_gnt    <= C_IC;
            r_ic_vld <= 1'b0;
            r_ld_vld <= 1'b0;
            r_st_vld <= 1'b0;
            r_val    <= 1'b0;
            r_rqtype <= 5'd0;
            r_size   <= 3'd0;
            r_addr   <= '0;
            r_data   <= 64'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_cap_ic) r_ic_vld <= 1'b1; else if (w_rel_ic) r_ic_vld <= 1'b0;
            if (w_cap_ld) r_ld_vld <= 1'b1; else if (w_rel_ld) r_ld_vld <= 1'b0;
            if (w_cap_st) r_st_vld <= 1'b1; else if (w_rel_st) r_st_vld <= 1'b0;
            if (w_drop)   r_ovf    <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_val   <= 1'b1;
                        r_gnt   <= w_win;
                        r_last  <= w_win;
                        r_state <= S_ISSUE;
                        case (w_win)
                            C_IC: begin
                                r_rqtype <= 5'b10000;
                                r_size   <= 3'b111;
                                r_addr   <= r_ic_addr & IC_MASK;
                                r_data   <= 64'd0;
                            end
                            C_LD: begin
                                r_rqtype <= 5'b00000;
                                r_size   <= 3'b111;
                                r_addr   <= r_ld_addr & DC_MASK;
                                r_data   <= 64'd0;
                            end
                            default: begin
                                r_rqtype <= 5'b00001;
                                r_size   <= {1'b0, r_st_size};
                                r_addr   <= r_st_addr;
                                r_data   <= f_st_data(r_st_data, r_st_size);
                            end
                        endcase
                    end
                end
                default: begin
                    if (l15_transducer_header_ack) begin
                        r_val   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign transducer_l15_val      = r_val;
    assign transducer_l15_rqtype   = r_rqtype;
    assign transducer_l15_size     = r_size;
    assign transducer_l15_address  = r_addr;
    assign transducer_l15_data     = r_data;
    assign transducer_l15_nc       = 1'b0;
    assign transducer_l15_threadid = 1'b0;
    assign anycore_req_overflow    = r_ovf;
endmodule

// File: tb/tb_anycore_l15_reqdecoder.sv
// Scoreboard bench for anycore_l15_reqdecoder: stimulus pushes expected requests,
// a negedge monitor pops and compares each new request the DUT presents.
module tb_anycore_l15_reqdecoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_v = 1'b0, ld_v = 1'b0, st_v = 1'b0;
    logic [39:0] ic_a = '0, ld_a = '0, st_a = '0;
    logic [63:0] st_d = '0;
    logic [1:0]  st_s = '0;
    logic        ack = 1'b0;
    logic        val, nc, tid, ovf;
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [63:0] data;

    typedef struct {
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [39:0] a;
        logic [63:0] d;
    } req_t;

    req_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    anycore_l15_reqdecoder #(.PADDR_W(40), .IC_OFFSET(5), .DC_OFFSET(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .anycore_ic2mem_reqvalid(ic_v), .anycore_ic2mem_reqaddr(ic_a),
        .anycore_dc2mem_ldvalid(ld_v), .anycore_dc2mem_ldaddr(ld_a),
        .anycore_dc2mem_stvalid(st_v), .anycore_dc2mem_staddr(st_a),
        .anycore_dc2mem_stdata(st_d), .anycore_dc2mem_stsize(st_s),
        .transducer_l15_val(val), .transducer_l15_rqtype(rqtype),
        .transducer_l15_size(size), .transducer_l15_address(addr),
        .transducer_l15_data(data), .transducer_l15_nc(nc),
        .transducer_l15_threadid(tid),
        .l15_transducer_header_ack(ack), .anycore_req_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rq, input logic [2:0] sz,
                        input logic [39:0] a, input logic [63:0] d);
        req_t r;
        r.rq = rq; r.sz = sz; r.a = a; r.d = d;
        q.push_back(r);
    endtask

    task automatic clr_pulses();
        ic_v = 1'b0; ld_v = 1'b0; st_v = 1'b0;
    endtask

    task automatic wait_val();
        for (int i = 0; i < 20 && !val; i++) @(negedge clk);
        if (!val) chk("val_timeout", 64'(val), 64'd1);
    endtask

    // Wait for val, hold ack low for 'hold' cycles, pulse ack, confirm val drops.
    task automatic do_ack(input int hold);
        wait_val();
        repeat (hold) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        clr_pulses();
        chk("val_drop", 64'(val), 64'd0);
    endtask

    // Monitor: a rising val pops the scoreboard; a held val must keep its fields.
    initial begin
        logic prev = 1'b0;
        req_t held;
        forever begin
            @(negedge clk);
            if (val) begin
                if (!prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_req", 64'(addr), 64'd0);
                        held.rq = rqtype; held.sz = size; held.a = addr; held.d = data;
                    end else begin
                        held = q.pop_front();
                        chk("req_rqtype", 64'(rqtype), 64'(held.rq));
                        chk("req_size",   64'(size),   64'(held.sz));
                        chk("req_addr",   64'(addr),   64'(held.a));
                        chk("req_data",   data,        held.d);
                        chk("req_nc_tid", 64'({nc, tid}), 64'd0);
                    end
                end else begin
                    chk("hold_fields", {rqtype, size, addr[15:0], data[39:0]},
                        {held.rq, held.sz, held.a[15:0], held.d[39:0]});
                    chk("hold_addr", 64'(addr), 64'(held.a));
                end
            end
            prev = val;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_val",    64'(val),    64'd0);
        chk("rst_rqtype", 64'(rqtype), 64'd0);
        chk("rst_size",   64'(size),   64'd0);
        chk("rst_addr",   64'(addr),   64'd0);
        chk("rst_data",   data,        64'd0);
        chk("rst_ovf",    64'(ovf),    64'd0);

        // Single ifetch: latency 2, fields held 3 cycles
        ic_v = 1'b1; ic_a = 40'h00_8000_0013;
        push(5'b10000, 3'b111, 40'h00_8000_0000, 64'd0);
        @(negedge clk);
        clr_pulses();
        chk("lat_cycle1", 64'(val), 64'd0);
        @(negedge clk);
        chk("lat_cycle2", 64'(val), 64'd1);
        do_ack(3);

        // Stores 1B and 4B
        st_v = 1'b1; st_a = 40'h100; st_s = 2'd0; st_d = 64'h1234_5678_9ABC_DEAB;
        push(5'b00001, 3'b000, 40'h100, 64'hABAB_ABAB_ABAB_ABAB);
        @(negedge clk);
        clr_pulses();
        do_ack(0);
        st_v = 1'b1; st_a = 40'h104; st_s = 2'd2; st_d = 64'h0000_0000_1122_3344;
        push(5'b00001, 3'b010, 40'h104, 64'h4433_2211_4433_2211);
        @(negedge clk);
        clr_pulses();
        do_ack(0);

        // Simultaneous ic/ld/st: granted IC, LD, ST
        ic_v = 1'b1; ic_a = 40'h10_0000_0027;
        ld_v = 1'b1; ld_a = 40'h20_0000_001F;
        st_v = 1'b1; st_a = 40'h300; st_s = 2'd3; st_d = 64'h0102_0304_0506_0708;
        push(5'b10000, 3'b111, 40'h10_0000_0020, 64'd0);
        push(5'b00000, 3'b111, 40'h20_0000_0010, 64'd0);
        push(5'b00001, 3'b011, 40'h300, 64'h0807_0605_0403_0201);
        @(negedge clk);
        clr_pulses();
        do_ack(0);
        do_ack(0);
        do_ack(0);

        // Fairness: IC refilled on its ack, pending LD still wins next
        ic_v = 1'b1; ic_a = 40'h40_0000_0000;
        ld_v = 1'b1; ld_a = 40'h50_0000_0000;
        push(5'b10000, 3'b111, 40'h40_0000_0000, 64'd0);
        push(5'b00000, 3'b111, 40'h50_0000_0000, 64'd0);
        push(5'b10000, 3'b111, 40'h60_0000_0040, 64'd0);
        @(negedge clk);
        clr_pulses();
        wait_val();
        ack = 1'b1; ic_v = 1'b1; ic_a = 40'h60_0000_0040;
        @(negedge clk);
        ack = 1'b0; clr_pulses();
        do_ack(0);
        do_ack(0);

        // Overflow: second load while first still held is dropped
        chk("ovf_clear", 64'(ovf), 64'd0);
        ld_v = 1'b1; ld_a = 40'h70_0000_0018;
        push(5'b00000, 3'b111, 40'h70_0000_0010, 64'd0);
        @(negedge clk);
        clr_pulses();
        wait_val();
        ld_v = 1'b1; ld_a = 40'h70_0000_0020;
        @(negedge clk);
        clr_pulses();
        chk("ovf_set", 64'(ovf), 64'd1);
        do_ack(1);
        repeat (4) @(negedge clk);
        chk("no_dropped_issue", 64'(val), 64'd0);

        // Load arriving on the same cycle as the LD ack is kept
        ld_v = 1'b1; ld_a = 40'h70_0000_0030;
        push(5'b00000, 3'b111, 40'h70_0000_0030, 64'd0);
        push(5'b00000, 3'b111, 40'h70_0000_0040, 64'd0);
        @(negedge clk);
        clr_pulses();
        wait_val();
        ack = 1'b1; ld_v = 1'b1; ld_a = 40'h70_0000_0044;
        @(negedge clk);
        ack = 1'b0; clr_pulses();
        chk("val_drop_refill", 64'(val), 64'd0);
        do_ack(0);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Reset during ISSUE abandons the request and clears overflow
        ic_v = 1'b1; ic_a = 40'h80_0000_0000;
        push(5'b10000, 3'b111, 40'h80_0000_0000, 64'd0);
        @(negedge clk);
        clr_pulses();
        wait_val();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_issue_val", 64'(val), 64'd0);
        chk("rst_issue_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_req", 64'(val), 64'd0);
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
